// File: rtl/pll_phase_stepper_if.sv
// -----------------------------------------------------------------------------
// pll_phase_stepper_if
// Command-side bus between the command decoder and the PLL phase stepper.
//   update        request strobe (accepted only while busy = 0)
//   cnt_sel       0..NCNT-1 selects Ck, 7 selects all counters
//   phase_target  absolute target phase in PLL step units
//   do_areset     pulse PLL areset (and clear trackers) before stepping
//   pll_clksrc    requested PLL input clock (0 = inclk0, 1 = inclk1)
//   rd_sel        tracker readback select
//   rd_phase      registered tracker readback
//   busy/done/err request status back to the command side
// master = command decoder, slave = phase stepper.
// -----------------------------------------------------------------------------
interface pll_phase_stepper_if #(
    parameter int PHASE_W = 8
) ();
    logic               update;
    logic [2:0]         cnt_sel;
    logic [PHASE_W-1:0] phase_target;
    logic               do_areset;
    logic               pll_clksrc;
    logic [2:0]         rd_sel;
    logic [PHASE_W-1:0] rd_phase;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output update, cnt_sel, phase_target, do_areset, pll_clksrc, rd_sel,
        input  rd_phase, busy, done, err
    );

    modport slave (
        input  update, cnt_sel, phase_target, do_areset, pll_clksrc, rd_sel,
        output rd_phase, busy, done, err
    );
endinterface

// File: rtl/pll_phase_stepper.sv
// -----------------------------------------------------------------------------
// pll_phase_stepper
// Dynamic-phase controller for a Cyclone-III-style PLL. Accepts "set counter k
// to absolute phase N" requests, tracks the phase offset of every output
// counter, and drives the PLL phasestep/scanclk protocol along the shortest
// signed path. Optionally pulses areset and clkswitch before stepping.
// Ports:
//   i_clk, i_reset          system clock, synchronous active-high reset
//   io_cmd                  command bus (pll_phase_stepper_if.slave)
//   i_phase_done            PLL phasedone (asynchronous, synchronised here)
//   o_areset, o_clkswitch   PLL reset / input clock switchover
//   o_phasestep, o_scanclk  PLL dynamic-phase step and scan clock
//   o_phaseupdown           step direction (1 = up)
//   o_phasecounterselect    PLL counter select (000 all, 010 C0 .. 110 C4)
// -----------------------------------------------------------------------------
module pll_phase_stepper #(
    parameter int NCNT        = 5,
    parameter int PHASE_W     = 8,
    parameter int DIV         = 16,
    parameter int ARESET_CYC  = 8,
    parameter int CLKSW_CYC   = 8,
    parameter int STEP_TOG    = 6,
    parameter int TIMEOUT_TOG = 108
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pll_phase_stepper_if.slave   io_cmd,
    input  logic                 i_phase_done,
    output logic                 o_areset,
    output logic                 o_clkswitch,
    output logic                 o_phasestep,
    output logic                 o_scanclk,
    output logic                 o_phaseupdown,
    output logic [2:0]           o_phasecounterselect
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARESET, S_SRC, S_CLKSW, S_CALC, S_STEP, S_ONEPHASE, S_FINISH
    } state_t;

    localparam logic [2:0]         SEL_ALL = 3'd7;
    localparam logic [2:0]         NCNT_3  = 3'(NCNT);
    localparam logic [PHASE_W-1:0] ZERO_PH = {PHASE_W{1'b0}};
    localparam logic [PHASE_W-1:0] ONE_PH  = {{(PHASE_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_state;
    logic [2:0]         r_sel, w_sel;
    logic [PHASE_W-1:0] r_target, w_target;
    logic               r_clksrc, w_clksrc;
    logic               r_cur_src, w_cur_src;
    logic [15:0]        r_cnt, w_cnt;       // hold-cycle count, reused as scanclk divider
    logic [15:0]        r_tog, w_tog;       // scanclk toggles in the current step
    logic [PHASE_W-1:0] r_n, w_n;           // steps remaining
    logic               r_dir, w_dir;
    logic [PHASE_W-1:0] r_trk [NCNT];
    logic [PHASE_W-1:0] w_trk [NCNT];
    logic               r_areset, w_areset;
    logic               r_clkswitch, w_clkswitch;
    logic               r_phasestep, w_phasestep;
    logic               r_scanclk, w_scanclk;
    logic               r_phaseupdown, w_phaseupdown;
    logic [2:0]         r_pcs, w_pcs;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic [PHASE_W-1:0] r_rd_phase, w_rd_val;
    logic               r_pd_meta, r_pd_sync;

    logic               w_sel_ok;
    logic [2:0]         w_ref_idx;
    logic [PHASE_W-1:0] w_ref_val;
    logic [PHASE_W-1:0] w_diff;
    logic [PHASE_W-1:0] w_mag;
    logic [15:0]        w_tog_inc;
    logic               w_div_end;

    // Two-flop synchroniser for the asynchronous PLL phasedone
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pd_meta <= 1'b0;
            r_pd_sync <= 1'b0;
        end else begin
            r_pd_meta <= i_phase_done;
            r_pd_sync <= r_pd_meta;
        end
    end

    // Tracker readback mux and shortest-path distance for the reference counter
    always_comb begin
        w_rd_val  = ZERO_PH;
        w_ref_val = ZERO_PH;
        w_ref_idx = (r_sel == SEL_ALL) ? 3'd0 : r_sel;
        for (int k = 0; k < NCNT; k++) begin
            if (io_cmd.rd_sel == 3'(k)) begin
                w_rd_val = r_trk[k];
            end else begin
                w_rd_val = w_rd_val;
            end
            if (w_ref_idx == 3'(k)) begin
                w_ref_val = r_trk[k];
            end else begin
                w_ref_val = w_ref_val;
            end
        end
        w_diff    = r_target - w_ref_val;
        // MSB set means going down is shorter (or equal at the half-way point)
        w_mag     = w_diff[PHASE_W-1] ? (ZERO_PH - w_diff) : w_diff;
        w_sel_ok  = (io_cmd.cnt_sel < NCNT_3) || (io_cmd.cnt_sel == SEL_ALL);
        w_tog_inc = r_tog + 16'd1;
        w_div_end = (r_cnt == 16'(DIV - 1));
    end

    // Next-state and next-output logic
    always_comb begin
        w_state       = r_state;
        w_sel         = r_sel;
        w_target      = r_target;
        w_clksrc      = r_clksrc;
        w_cur_src     = r_cur_src;
        w_cnt         = r_cnt;
        w_tog         = r_tog;
        w_n           = r_n;
        w_dir         = r_dir;
        w_areset      = r_areset;
        w_clkswitch   = r_clkswitch;
        w_phasestep   = r_phasestep;
        w_scanclk     = r_scanclk;
        w_phaseupdown = r_phaseupdown;
        w_pcs         = r_pcs;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_err         = r_err;
        for (int k = 0; k < NCNT; k++) begin
            w_trk[k] = r_trk[k];
        end

        case (r_state)
            S_IDLE: begin
                // busy can still be high here for the done cycle; requests then are ignored
                if (io_cmd.update && !r_busy) begin
                    w_sel    = io_cmd.cnt_sel;
                    w_target = io_cmd.phase_target;
                    w_clksrc = io_cmd.pll_clksrc;
                    w_busy   = 1'b1;
                    w_err    = 1'b0;
                    if (!w_sel_ok) begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end else if (io_cmd.do_areset) begin
                        w_areset = 1'b1;
                        w_cnt    = 16'd0;
                        w_state  = S_ARESET;
                    end else begin
                        w_state = S_SRC;
                    end
                end else begin
                    w_busy = 1'b0;
                end
            end
            S_ARESET: begin
                if (r_cnt == 16'(ARESET_CYC - 1)) begin
                    w_areset = 1'b0;
                    for (int k = 0; k < NCNT; k++) begin
                        w_trk[k] = ZERO_PH;
                    end
                    w_state = S_SRC;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_SRC: begin
                if (r_clksrc != r_cur_src) begin
                    w_clkswitch = 1'b1;
                    w_cnt       = 16'd0;
                    w_state     = S_CLKSW;
                end else begin
                    w_state = S_CALC;
                end
            end
            S_CLKSW: begin
                if (r_cnt == 16'(CLKSW_CYC - 1)) begin
                    w_clkswitch = 1'b0;
                    w_cur_src   = ~r_cur_src;
                    w_state     = S_CALC;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_CALC: begin
                w_dir = ~w_diff[PHASE_W-1];
                w_n   = w_mag;
                if (w_mag == ZERO_PH) begin
                    w_state = S_FINISH;
                end else begin
                    w_state = S_STEP;
                end
            end
            S_STEP: begin
                w_pcs         = (r_sel == SEL_ALL) ? 3'b000 : (r_sel + 3'd2);
                w_phaseupdown = r_dir;
                w_scanclk     = 1'b0;
                w_phasestep   = 1'b1;
                w_cnt         = 16'd0;
                w_tog         = 16'd0;
                w_state       = S_ONEPHASE;
            end
            S_ONEPHASE: begin
                if (w_div_end) begin
                    w_cnt     = 16'd0;
                    w_scanclk = ~r_scanclk;
                    w_tog     = w_tog_inc;
                    if (w_tog_inc == 16'(STEP_TOG)) begin
                        w_phasestep = 1'b0;
                    end else begin
                        w_phasestep = r_phasestep;
                    end
                    // phasedone is only trusted from the 8th toggle on
                    if ((w_tog_inc >= 16'd8) && r_pd_sync) begin
                        for (int k = 0; k < NCNT; k++) begin
                            if ((r_sel == SEL_ALL) || (r_sel == 3'(k))) begin
                                w_trk[k] = r_dir ? (r_trk[k] + ONE_PH) : (r_trk[k] - ONE_PH);
                            end else begin
                                w_trk[k] = r_trk[k];
                            end
                        end
                        w_n = r_n - ONE_PH;
                        if (r_n == ONE_PH) begin
                            w_scanclk   = 1'b0;
                            w_phasestep = 1'b0;
                            w_state     = S_FINISH;
                        end else begin
                            w_state = S_STEP;
                        end
                    end else if (w_tog_inc == 16'(TIMEOUT_TOG)) begin
                        w_err       = 1'b1;
                        w_scanclk   = 1'b0;
                        w_phasestep = 1'b0;
                        w_state     = S_FINISH;
                    end else begin
                        w_state = S_ONEPHASE;
                    end
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_FINISH: begin
                w_scanclk   = 1'b0;
                w_phasestep = 1'b0;
                w_done      = ~r_err;
                // busy stays up through the done cycle, dropped from IDLE
                w_busy      = 1'b1;
                w_state     = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_sel         <= 3'd0;
            r_target      <= ZERO_PH;
            r_clksrc      <= 1'b0;
            r_cur_src     <= 1'b0;
            r_cnt         <= 16'd0;
            r_tog         <= 16'd0;
            r_n           <= ZERO_PH;
            r_dir         <= 1'b1;
            r_areset      <= 1'b0;
            r_clkswitch   <= 1'b0;
            r_phasestep   <= 1'b0;
            r_scanclk     <= 1'b0;
            r_phaseupdown <= 1'b1;
            r_pcs         <= 3'b010;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            for (int k = 0; k < NCNT; k++) begin
                r_trk[k] <= ZERO_PH;
            end
        end else begin
            r_state       <= w_state;
            r_sel         <= w_sel;
            r_target      <= w_target;
            r_clksrc      <= w_clksrc;
            r_cur_src     <= w_cur_src;
            r_cnt         <= w_cnt;
            r_tog         <= w_tog;
            r_n           <= w_n;
            r_dir         <= w_dir;
            r_areset      <= w_areset;
            r_clkswitch   <= w_clkswitch;
            r_phasestep   <= w_phasestep;
            r_scanclk     <= w_scanclk;
            r_phaseupdown <= w_phaseupdown;
            r_pcs         <= w_pcs;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err         <= w_err;
            for (int k = 0; k < NCNT; k++) begin
                r_trk[k] <= w_trk[k];
            end
        end
    end

    // Registered tracker readback
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_phase <= ZERO_PH;
        end else begin
            r_rd_phase <= w_rd_val;
        end
    end

    assign io_cmd.rd_phase      = r_rd_phase;
    assign io_cmd.busy          = r_busy;
    assign io_cmd.done          = r_done;
    assign io_cmd.err           = r_err;
    assign o_areset             = r_areset;
    assign o_clkswitch          = r_clkswitch;
    assign o_phasestep          = r_phasestep;
    assign o_scanclk            = r_scanclk;
    assign o_phaseupdown        = r_phaseupdown;
    assign o_phasecounterselect = r_pcs;
endmodule
